ahb_fir_stats: RTL

//  AHB-lite slave that taps the FIR output stream (out_wave/write_en) in parallel with the FIFO.

---
 rtl/ahb_fir_stats.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_fir_stats.sv
// ahb_fir_stats
//   AHB-lite slave that watches the FIR output stream (out_wave/write_en)
//   alongside the FIFO. It collects per-window statistics: maximum,
//   minimum, signed sum and sample count. At each window end it copies
//   the results into shadow registers and raises a sticky done flag,
//   which can also drive an interrupt. Software reads the results over AHB.
//
// Ports
//   clk, rst            system clock; asynchronous active-high reset
//   hready, hsel        bus ready from the mux, slave select from the decoder
//   haddr, hwrite       address-phase controls; haddr[4:2] select the register
//   hsize, htrans       transfer size (ignored), transfer type
//   hwdata              write data, data phase
//   hrdata              read data, data phase (combinational mux)
//   hreadyout, hresp    always ready, always OKAY
//   out_wave, write_en  FIR output sample and its valid strobe
//   irq                 done & interrupt enable
//
// Register map (byte offset)
//   0x00 CTRL   [0] en, [1] clr (self-clearing), [2] ie, [3] oneshot
//   0x04 STATUS [0] done (W1C), [1] overrun (W1C), [2] busy (RO)
//   0x08 WINLEN window length, clamped to 1..2**WIN_LOG2
//   0x0C COUNT  live sample count
//   0x10 MAX, 0x14 MIN, 0x18 SUMLO, 0x1C SUMHI  shadowed results
module ahb_fir_stats #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int OUT_SIZE = 32,
    parameter int WIN_LOG2 = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hready,
    input  logic [AWIDTH-1:0]   haddr,
    input  logic                hwrite,
    input  logic [2:0]          hsize,
    input  logic [1:0]          htrans,
    input  logic [DWIDTH-1:0]   hwdata,
    input  logic                hsel,
    output logic [DWIDTH-1:0]   hrdata,
    output logic                hreadyout,
    output logic                hresp,
    input  logic [OUT_SIZE-1:0] out_wave,
    input  logic                write_en,
    output logic                irq
);

    localparam int SUM_W = OUT_SIZE + WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;

    localparam logic [CNT_W-1:0]           WIN_MAX  = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic signed [OUT_SIZE-1:0] SMP_POS  = {1'b0, {(OUT_SIZE-1){1'b1}}};
    localparam logic signed [OUT_SIZE-1:0] SMP_NEG  = {1'b1, {(OUT_SIZE-1){1'b0}}};

    // Out-of-range window lengths (0 or above the accumulator capacity) fall
    // back to the maximum so the window always terminates.
    function automatic logic [CNT_W-1:0] clamp_winlen(input logic [DWIDTH-1:0] v);
        if (v == '0 || v > DWIDTH'(WIN_MAX))
            return WIN_MAX;
        else
            return v[CNT_W-1:0];
    endfunction

    function automatic logic signed [OUT_SIZE-1:0] smax(
        input logic signed [OUT_SIZE-1:0] a,
        input logic signed [OUT_SIZE-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [OUT_SIZE-1:0] smin(
        input logic signed [OUT_SIZE-1:0] a,
        input logic signed [OUT_SIZE-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    // ---------------- stage p0: AHB address phase ----------------
    logic       vld_p0;
    logic       vld_p1;
    logic [2:0] addr_p1;
    logic       write_p1;

    assign vld_p0 = hsel & hready & htrans[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            write_p1 <= 1'b0;
        end else if (hready) begin
            vld_p1   <= vld_p0;
            addr_p1  <= haddr[4:2];
            write_p1 <= hwrite;
        end
    end

    // ---------------- stage p1: AHB data phase ----------------
    logic wr_p1;
    logic rd_p1;
    logic wr_ctrl_p1;
    logic wr_status_p1;
    logic wr_winlen_p1;
    logic clr_p1;

    assign wr_p1        = vld_p1 & write_p1;
    assign rd_p1        = vld_p1 & ~write_p1;
    assign wr_ctrl_p1   = wr_p1 && (addr_p1 == 3'd0);
    assign wr_status_p1 = wr_p1 && (addr_p1 == 3'd1);
    assign wr_winlen_p1 = wr_p1 && (addr_p1 == 3'd2);
    assign clr_p1       = wr_ctrl_p1 & hwdata[1];

    // Control and status state
    logic             ctrl_en;
    logic             ctrl_ie;
    logic             ctrl_oneshot;
    logic             sts_done;
    logic             sts_overrun;
    logic [CNT_W-1:0] winlen;

    // Accumulators and shadows
    logic [CNT_W-1:0]           cnt;
    logic signed [OUT_SIZE-1:0] max_acc;
    logic signed [OUT_SIZE-1:0] min_acc;
    logic signed [SUM_W-1:0]    sum_acc;
    logic signed [OUT_SIZE-1:0] shd_max;
    logic signed [OUT_SIZE-1:0] shd_min;
    logic signed [SUM_W-1:0]    shd_sum;

    // Next-sample values; a clear in the same cycle drops the sample.
    logic                       accept;
    logic                       win_end;
    logic signed [OUT_SIZE-1:0] smp;
    logic [CNT_W-1:0]           cnt_inc;
    logic signed [OUT_SIZE-1:0] max_new;
    logic signed [OUT_SIZE-1:0] min_new;
    logic signed [SUM_W-1:0]    sum_new;

    assign smp     = out_wave;
    assign accept  = ctrl_en & write_en & ~clr_p1;
    assign cnt_inc = cnt + CNT_W'(1);
    assign max_new = smax(max_acc, smp);
    assign min_new = smin(min_acc, smp);
    assign sum_new = sum_acc + SUM_W'(smp);
    // ">=" lets a shortened WINLEN close the window on the next sample.
    assign win_end = accept & (cnt_inc >= winlen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            max_acc <= SMP_NEG;
            min_acc <= SMP_POS;
            sum_acc <= '0;
        end else if (clr_p1 || win_end) begin
            cnt     <= '0;
            max_acc <= SMP_NEG;
            min_acc <= SMP_POS;
            sum_acc <= '0;
        end else if (accept) begin
            cnt     <= cnt_inc;
            max_acc <= max_new;
            min_acc <= min_new;
            sum_acc <= sum_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_max <= '0;
            shd_min <= '0;
            shd_sum <= '0;
        end else if (win_end) begin
            shd_max <= max_new;
            shd_min <= min_new;
            shd_sum <= sum_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en      <= 1'b0;
            ctrl_ie      <= 1'b0;
            ctrl_oneshot <= 1'b0;
        end else begin
            if (wr_ctrl_p1) begin
                ctrl_en      <= hwdata[0];
                ctrl_ie      <= hwdata[2];
                ctrl_oneshot <= hwdata[3];
            end
            if (win_end && ctrl_oneshot)
                ctrl_en <= 1'b0;
        end
    end

    // Hardware set takes priority over a simultaneous software clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sts_done    <= 1'b0;
            sts_overrun <= 1'b0;
        end else begin
            sts_done    <= win_end | (sts_done & ~(wr_status_p1 & hwdata[0]));
            sts_overrun <= (win_end & sts_done)
                         | (sts_overrun & ~(wr_status_p1 & hwdata[1]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            winlen <= WIN_MAX;
        else if (wr_winlen_p1)
            winlen <= clamp_winlen(hwdata);
    end

    // Read mux
    logic                  busy;
    logic [2*DWIDTH-1:0]   sum_ext;
    logic [DWIDTH-1:0]     rdata;

    assign busy    = ctrl_en & (cnt != '0);
    assign sum_ext = (2*DWIDTH)'(shd_sum);

    always_comb begin
        rdata = '0;
        if (rd_p1) begin
            case (addr_p1)
                3'd0:    rdata = {{(DWIDTH-4){1'b0}}, ctrl_oneshot, ctrl_ie, 1'b0, ctrl_en};
                3'd1:    rdata = {{(DWIDTH-3){1'b0}}, busy, sts_overrun, sts_done};
                3'd2:    rdata = DWIDTH'(winlen);
                3'd3:    rdata = DWIDTH'(cnt);
                3'd4:    rdata = DWIDTH'(shd_max);
                3'd5:    rdata = DWIDTH'(shd_min);
                3'd6:    rdata = sum_ext[DWIDTH-1:0];
                3'd7:    rdata = sum_ext[2*DWIDTH-1:DWIDTH];
                default: rdata = '0;
            endcase
        end
    end

    assign hrdata    = rdata;
    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;
    assign irq       = sts_done & ctrl_ie;

    logic unused_ok;
    assign unused_ok = &{1'b0, haddr[AWIDTH-1:5], haddr[1:0], hsize, htrans[0]};

endmodule
